// File: rtl/uart_tx_arbiter_if.sv
// Signals between the two-requester UART transmit arbiter and its users.
// The requester side is the master and the arbiter is the slave.
interface uart_tx_arbiter_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       txd;
    logic       busy;
    logic       grant_id;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1, txd, busy, grant_id
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1, txd, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises bytes from two requesters onto one 8N1 UART line.
// An optional idle gap follows every stop bit.
module uart_tx_arbiter #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int GAP_BITS     = 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CYC_COUNT = SYSTEM_CLOCK / BAUD_RATE;
    localparam int CW        = (CYC_COUNT > 1) ? $clog2(CYC_COUNT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYC_COUNT - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [3:0]    gap_cnt, gap_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          txd_q, txd_next;
    logic          ack0_q, ack0_next;
    logic          ack1_q, ack1_next;
    logic          grant_q, grant_next;
    logic          last_q, last_next;
    logic          pick;
    logic          bit_done;

    assign bit_done = (cnt == CYC_LAST);

    // The round-robin pointer resets to "1 was last" so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            txd_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            gap_cnt <= gap_cnt_next;
            shift   <= shift_next;
            txd_q   <= txd_next;
            ack0_q  <= ack0_next;
            ack1_q  <= ack1_next;
            grant_q <= grant_next;
            last_q  <= last_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        gap_cnt_next = gap_cnt;
        shift_next   = shift;
        txd_next     = txd_q;
        ack0_next    = 1'b0;
        ack1_next    = 1'b0;
        grant_next   = grant_q;
        last_next    = last_q;
        pick         = 1'b0;

        if (state != IDLE) begin
            cnt_next = bit_done ? '0 : cnt + 1'b1;
        end

        // Every line value is computed one cycle ahead so txd comes straight from a flop.
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (bus.req0 || bus.req1) begin
                    pick       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    grant_next = pick;
                    last_next  = pick;
                    shift_next = pick ? bus.data1 : bus.data0;
                    ack0_next  = ~pick;
                    ack1_next  = pick;
                    txd_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_idx_next = 3'd0;
                    txd_next     = shift[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        txd_next = shift[bit_idx_next];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    gap_cnt_next = 4'd0;
                    state_next   = (GAP_BITS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (bit_done) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    assign bus.txd      = txd_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = (state != IDLE);
    assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level model predicts grants and line waveforms.
// A monitor consumes the predictions whenever the arbiter acknowledges a byte.
module tb_uart_tx_arbiter;
    localparam int SYSTEM_CLOCK = 60;
    localparam int BAUD_RATE    = 10;
    localparam int GAP_BITS     = 2;
    localparam int BIT_CYC      = SYSTEM_CLOCK / BAUD_RATE;
    localparam int BUSY_CYC     = (10 + GAP_BITS) * BIT_CYC;
    localparam int ACK_SPACING  = BUSY_CYC + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    frame_t     exp_q[$];
    bit         pend [2];
    logic [7:0] pdat [2];
    int         idle_from = 0;
    int         last_g = 1;
    int         just_granted = -1;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .SYSTEM_CLOCK(SYSTEM_CLOCK),
        .BAUD_RATE   (BAUD_RATE),
        .GAP_BITS    (GAP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // One cycle of requester behaviour plus the model's decision for the coming edge.
    // mode 0: random traffic with withdrawals, 1: both always requesting, 2: no new bytes.
    task automatic applyStimulus(input int mode);
        int g;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (i == just_granted) begin
                if (mode == 1 || (mode == 0 && $urandom_range(1) == 1)) begin
                    pdat[i] = 8'($urandom);
                end else begin
                    pend[i] = 1'b0;
                end
            end else if (mode == 1) begin
                if (!pend[i]) begin
                    pend[i] = 1'b1;
                    pdat[i] = 8'($urandom);
                end
            end else if (mode == 0) begin
                if (!pend[i] && $urandom_range(7) == 0) begin
                    pend[i] = 1'b1;
                    pdat[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        just_granted = -1;
        bus.req0  = pend[0];
        bus.data0 = pdat[0];
        bus.req1  = pend[1];
        bus.data1 = pdat[1];
        if (!rst && (cyc + 1) >= idle_from && (pend[0] || pend[1])) begin
            g = (pend[0] && pend[1]) ? (1 - last_g) : (pend[0] ? 0 : 1);
            exp_q.push_back('{id: g, data: pdat[g], cyc: cyc + 1});
            last_g       = g;
            idle_from    = cyc + 1 + ACK_SPACING;
            just_granted = g;
        end
    endtask

    // Monitor: pops the predicted frame on each ack, then checks the line cycle by cycle.
    initial begin
        frame_t cur;
        bit     cur_valid;
        int     exp_gid;
        int     off;
        logic   exp_txd;
        logic   exp_busy;
        cur_valid = 1'b0;
        exp_gid   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cur_valid = 1'b0;
                exp_gid   = 0;
                checkOutput("rst_txd", bus.txd, 1);
                checkOutput("rst_busy", bus.busy, 0);
                checkOutput("rst_ack0", bus.ack0, 0);
                checkOutput("rst_ack1", bus.ack1, 0);
                checkOutput("rst_grant_id", bus.grant_id, 0);
            end else begin
                checkOutput("ack_exclusive", bus.ack0 & bus.ack1, 0);
                if (bus.ack0 || bus.ack1) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("ack_unexpected", bus.ack0 | bus.ack1, 0);
                    end else begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1'b1;
                        exp_gid   = cur.id;
                        checkOutput("ack_id", bus.ack1, 32'(cur.id));
                        checkOutput("ack_cycle", cyc, cur.cyc);
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checkOutput("ack_missing", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
                if (cur_valid) begin
                    off = cyc - cur.cyc;
                    if (off < BUSY_CYC) exp_busy = 1'b1;
                    if (off < BIT_CYC) begin
                        exp_txd = 1'b0;
                    end else if (off < 9 * BIT_CYC) begin
                        exp_txd = cur.data[off / BIT_CYC - 1];
                    end
                end
                checkOutput("txd", bus.txd, exp_txd);
                checkOutput("busy", bus.busy, exp_busy);
                checkOutput("grant_id", bus.grant_id, exp_gid);
            end
        end
    end

    initial begin
        int frame_start;
        bus.req0  = 1'b0;
        bus.data0 = 8'h00;
        bus.req1  = 1'b0;
        bus.data1 = 8'h00;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pdat[0] = 8'h00;
        pdat[1] = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", bus.txd, 1);
        checkOutput("reset_busy", bus.busy, 0);
        rst = 1'b0;
        $display("[TB] reset released, simultaneous requests 0xA5 / 0x3C");

        pend[0] = 1'b1;
        pdat[0] = 8'hA5;
        pend[1] = 1'b1;
        pdat[1] = 8'h3C;
        repeat (2 * ACK_SPACING + 10) applyStimulus(2);

        $display("[TB] sustained contention");
        repeat (6 * ACK_SPACING) applyStimulus(1);
        repeat (3 * ACK_SPACING) applyStimulus(2);

        $display("[TB] random traffic with withdrawn requests");
        repeat (2500) applyStimulus(0);
        repeat (3 * ACK_SPACING) applyStimulus(2);

        $display("[TB] reset during data bit 3 of 0x00");
        pend[0] = 1'b1;
        pdat[0] = 8'h00;
        applyStimulus(2);
        frame_start = idle_from - ACK_SPACING;
        while (cyc < frame_start + 4 * BIT_CYC + BIT_CYC / 2) applyStimulus(2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_txd", bus.txd, 1);
        checkOutput("async_rst_busy", bus.busy, 0);
        checkOutput("async_rst_ack0", bus.ack0, 0);
        exp_q.delete();
        pend[0]      = 1'b0;
        pend[1]      = 1'b0;
        just_granted = -1;
        last_g       = 1;
        idle_from    = 0;
        repeat (3) applyStimulus(2);
        @(negedge clk);
        rst = 1'b0;
        pend[1] = 1'b1;
        pdat[1] = 8'hFF;
        repeat (2 * ACK_SPACING) applyStimulus(2);

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
